i2s_tx_sched: RTL and testbench

Stereo sample scheduler feeding the 48 kHz I2S transmitter. Two streaming sources, for example the microphone path and a tone/BRAM player, offer 24-bit stereo pairs over valid/ready handshakes. The block selects or mixes them, buffers the result in a small FIFO, and presents one pair per `data_rd` pulse. The pair is held stable until the transmitter loads it, on the second clock edge after the pulse. Underruns output silence and are counted.

---
 rtl/i2s_pkg.sv | 33 +++
 rtl/stereo_fifo.sv | 69 ++++++
 rtl/i2s_tx_sched.sv | 112 +++++++++++
 tb/tb_i2s_tx_sched.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
// Shared types and helpers for the I2S transmit scheduler: sample width, source
// policy encodings, the stereo pair type and the saturating channel adder.
package i2s_pkg;

    localparam int W = 24;

    typedef enum logic [1:0] {
        MODE_S0   = 2'd0,
        MODE_S1   = 2'd1,
        MODE_MIX  = 2'd2,
        MODE_RSVD = 2'd3
    } mode_e;

    typedef struct packed {
        logic [W-1:0] l;
        logic [W-1:0] r;
    } stereo_t;

    localparam logic [W-1:0] SAMPLE_MAX = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] SAMPLE_MIN = {1'b1, {(W-1){1'b0}}};

    // A carry bit that disagrees with the sign bit means the W+1-bit sum left the W-bit range.
    function automatic logic [W-1:0] sat_add(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] sum;
        sum = {a[W-1], a} + {b[W-1], b};
        if (sum[W] != sum[W-1]) begin
            sat_add = sum[W] ? SAMPLE_MIN : SAMPLE_MAX;
        end else begin
            sat_add = sum[W-1:0];
        end
    endfunction

endpackage

// File: rtl/stereo_fifo.sv
// Synchronous FIFO of stereo pairs with a registered read port that can load
// silence instead of the head entry.
module stereo_fifo
    import i2s_pkg::*;
#(
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_push,
    input  stereo_t       i_wdata,
    input  logic          i_pop,
    input  logic          i_load,
    input  logic          i_zero,
    output stereo_t       o_rdata,
    output logic [AW:0]   o_level,
    output logic          o_full,
    output logic          o_empty
);

    localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW:0]   LVL_ONE  = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);

    stereo_t       r_mem [DEPTH];
    stereo_t       r_rdata;
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_level;

    // Pointers, occupancy and the read register; pointers wrap naturally at DEPTH.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
            r_rdata <= '0;
        end else begin
            if (i_push) begin
                r_wptr <= r_wptr + PTR_ONE;
            end
            if (i_pop) begin
                r_rptr <= r_rptr + PTR_ONE;
            end
            case ({i_push, i_pop})
                2'b10:   r_level <= r_level + LVL_ONE;
                2'b01:   r_level <= r_level - LVL_ONE;
                default: r_level <= r_level;
            endcase
            if (i_load) begin
                r_rdata <= i_zero ? '0 : r_mem[r_rptr];
            end
        end
    end

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge i_clk) begin
        if (i_push) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    assign o_rdata = r_rdata;
    assign o_level = r_level;
    assign o_full  = (r_level == LVL_FULL);
    assign o_empty = (r_level == '0);

endmodule

// File: rtl/i2s_tx_sched.sv
// Stereo sample scheduler: selects or mixes two stereo sources into a FIFO and
// hands one pair per transmitter request, substituting silence on underrun.
module i2s_tx_sched
    import i2s_pkg::*;
#(
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic [1:0]    i_mode,
    input  logic          i_mute,
    input  logic          i_s0_valid,
    input  logic          i_s1_valid,
    output logic          o_s0_ready,
    output logic          o_s1_ready,
    input  logic [W-1:0]  i_s0_l,
    input  logic [W-1:0]  i_s0_r,
    input  logic [W-1:0]  i_s1_l,
    input  logic [W-1:0]  i_s1_r,
    input  logic          i_data_rd,
    output logic [W-1:0]  o_data_l,
    output logic [W-1:0]  o_data_r,
    output logic          o_underrun,
    output logic [15:0]   o_underrun_cnt,
    output logic [AW:0]   o_level
);

    localparam logic [15:0] CNT_MAX = 16'hFFFF;
    localparam logic [15:0] CNT_ONE = 16'h0001;

    logic        w_s0_ready;
    logic        w_s1_ready;
    logic        w_push;
    stereo_t     w_wdata;
    stereo_t     w_rdata;
    logic        w_full;
    logic        w_empty;
    logic        w_pop;
    logic        w_underrun;
    logic        r_underrun;
    logic [15:0] r_underrun_cnt;

    // Source arbitration; in mix mode both sources must be present so they are consumed together.
    always_comb begin
        w_s0_ready = 1'b0;
        w_s1_ready = 1'b0;
        w_push     = 1'b0;
        w_wdata    = '0;
        case (mode_e'(i_mode))
            MODE_S1: begin
                w_s1_ready = !w_full && !i_rst;
                w_push     = w_s1_ready && i_s1_valid;
                w_wdata.l  = i_s1_l;
                w_wdata.r  = i_s1_r;
            end
            MODE_MIX: begin
                w_s0_ready = !w_full && !i_rst && i_s0_valid && i_s1_valid;
                w_s1_ready = w_s0_ready;
                w_push     = w_s0_ready;
                w_wdata.l  = sat_add(i_s0_l, i_s1_l);
                w_wdata.r  = sat_add(i_s0_r, i_s1_r);
            end
            default: begin
                w_s0_ready = !w_full && !i_rst;
                w_push     = w_s0_ready && i_s0_valid;
                w_wdata.l  = i_s0_l;
                w_wdata.r  = i_s0_r;
            end
        endcase
    end

    assign w_pop      = i_data_rd && !w_empty;
    assign w_underrun = i_data_rd && w_empty;

    stereo_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (w_push),
        .i_wdata (w_wdata),
        .i_pop   (w_pop),
        .i_load  (i_data_rd),
        .i_zero  (i_mute || w_empty),
        .o_rdata (w_rdata),
        .o_level (o_level),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Underrun pulse and its saturating counter.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_underrun     <= 1'b0;
            r_underrun_cnt <= '0;
        end else begin
            r_underrun <= w_underrun;
            if (w_underrun && (r_underrun_cnt != CNT_MAX)) begin
                r_underrun_cnt <= r_underrun_cnt + CNT_ONE;
            end
        end
    end

    assign o_s0_ready     = w_s0_ready;
    assign o_s1_ready     = w_s1_ready;
    assign o_data_l       = w_rdata.l;
    assign o_data_r       = w_rdata.r;
    assign o_underrun     = r_underrun;
    assign o_underrun_cnt = r_underrun_cnt;

endmodule

// File: tb/tb_i2s_tx_sched.sv
// Directed self-checking bench for i2s_tx_sched: source policies, mixing
// saturation, underrun counting, full-FIFO back-pressure, mute and reset.
module tb_i2s_tx_sched;
    import i2s_pkg::*;

    localparam int DEPTH = 16;
    localparam int AW    = $clog2(DEPTH);

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    mode;
    logic          mute;
    logic          s0_valid, s1_valid;
    logic          s0_ready, s1_ready;
    logic [W-1:0]  s0_l, s0_r, s1_l, s1_r;
    logic          data_rd;
    logic [W-1:0]  data_l, data_r;
    logic          underrun;
    logic [15:0]   underrun_cnt;
    logic [AW:0]   level;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    i2s_tx_sched #(.DEPTH(DEPTH)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_mode         (mode),
        .i_mute         (mute),
        .i_s0_valid     (s0_valid),
        .i_s1_valid     (s1_valid),
        .o_s0_ready     (s0_ready),
        .o_s1_ready     (s1_ready),
        .i_s0_l         (s0_l),
        .i_s0_r         (s0_r),
        .i_s1_l         (s1_l),
        .i_s1_r         (s1_r),
        .i_data_rd      (data_rd),
        .o_data_l       (data_l),
        .o_data_r       (data_r),
        .o_underrun     (underrun),
        .o_underrun_cnt (underrun_cnt),
        .o_level        (level)
    );

    task automatic check_val(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One-cycle push from source 0 (mode 0 context), ready must be high.
    task automatic push0(input logic [W-1:0] l, input logic [W-1:0] r);
        @(negedge clk);
        s0_l     = l;
        s0_r     = r;
        s0_valid = 1'b1;
        #1;
        check_val("push_s0_ready", 48'(s0_ready), 48'd1);
        @(negedge clk);
        s0_valid = 1'b0;
    endtask

    // One-cycle data_rd pulse, then check the pair and underrun flag in the following cycle.
    task automatic pop_check(input string tag, input logic [47:0] exp, input logic exp_ur);
        @(negedge clk);
        data_rd = 1'b1;
        @(negedge clk);
        data_rd = 1'b0;
        check_val({tag, "_data"}, {data_l, data_r}, exp);
        check_val({tag, "_ur"}, 48'(underrun), 48'(exp_ur));
    endtask

    initial begin
        logic [W-1:0] exp_l;
        logic [W-1:0] exp_r;

        rst = 1'b1; mode = 2'd0; mute = 1'b0; data_rd = 1'b0;
        s0_valid = 1'b0; s1_valid = 1'b0;
        s0_l = '0; s0_r = '0; s1_l = '0; s1_r = '0;

        // Reset state and readies held low while in reset
        @(negedge clk);
        s0_valid = 1'b1;
        #1;
        check_val("rst_s0_ready", 48'(s0_ready), 48'd0);
        check_val("rst_s1_ready", 48'(s1_ready), 48'd0);
        @(negedge clk);
        rst = 1'b0;
        s0_valid = 1'b0;
        @(negedge clk);
        check_val("rst_data", {data_l, data_r}, 48'd0);
        check_val("rst_underrun", 48'(underrun), 48'd0);
        check_val("rst_cnt", 48'(underrun_cnt), 48'd0);
        check_val("rst_level", 48'(level), 48'd0);

        // Mode 0: two pairs in order, src1 ignored
        mode = 2'd0;
        s1_valid = 1'b1; s1_l = 24'h0000AA; s1_r = 24'h0000BB;
        push0(24'h000001, 24'h000002);
        push0(24'h000003, 24'h000004);
        check_val("m0_level2", 48'(level), 48'd2);
        check_val("m0_s1_ready", 48'(s1_ready), 48'd0);
        pop_check("m0_pop1", {24'h000001, 24'h000002}, 1'b0);
        check_val("m0_level1", 48'(level), 48'd1);
        repeat (2046) @(negedge clk);
        check_val("m0_hold", {data_l, data_r}, {24'h000001, 24'h000002});
        pop_check("m0_pop2", {24'h000003, 24'h000004}, 1'b0);
        check_val("m0_level0", 48'(level), 48'd0);
        s1_valid = 1'b0;

        // Mode 2: saturating mix, then an in-range mix
        mode = 2'd2;
        @(negedge clk);
        s0_l = 24'h7FFFF0; s0_r = 24'h800010; s1_l = 24'h000020; s1_r = 24'hFFFFE0;
        s0_valid = 1'b1; s1_valid = 1'b1;
        #1;
        check_val("mix_s0_ready", 48'(s0_ready), 48'd1);
        check_val("mix_s1_ready", 48'(s1_ready), 48'd1);
        @(negedge clk);
        s0_valid = 1'b0; s1_valid = 1'b0;
        check_val("mix_level1", 48'(level), 48'd1);
        pop_check("mix_sat", {24'h7FFFFF, 24'h800000}, 1'b0);
        @(negedge clk);
        s0_l = 24'h000005; s0_r = 24'hFFFFFF; s1_l = 24'h000003; s1_r = 24'hFFFFFE;
        s0_valid = 1'b1; s1_valid = 1'b1;
        @(negedge clk);
        s0_valid = 1'b0; s1_valid = 1'b0;
        pop_check("mix_sum", {24'h000008, 24'hFFFFFD}, 1'b0);
        check_val("mix_level0", 48'(level), 48'd0);

        // Mode 2 with only src0 valid: nothing accepted
        s0_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_val("mix_half_s0_ready", 48'(s0_ready), 48'd0);
            check_val("mix_half_s1_ready", 48'(s1_ready), 48'd0);
        end
        check_val("mix_half_level", 48'(level), 48'd0);
        s0_valid = 1'b0;

        // Underrun on an empty FIFO, three times
        mode = 2'd0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            data_rd = 1'b1;
            #1;
            check_val("ur_pre", 48'(underrun), 48'd0);
            @(negedge clk);
            data_rd = 1'b0;
            check_val("ur_data", {data_l, data_r}, 48'd0);
            check_val("ur_pulse", 48'(underrun), 48'd1);
            @(negedge clk);
            check_val("ur_post", 48'(underrun), 48'd0);
        end
        check_val("ur_cnt3", 48'(underrun_cnt), 48'd3);

        // Counter saturation from a preloaded value
        @(negedge clk);
        force dut.r_underrun_cnt = 16'hFFFE;
        #1;
        release dut.r_underrun_cnt;
        pop_check("ur_sat1", 48'd0, 1'b1);
        check_val("ur_cnt_ffff", 48'(underrun_cnt), 48'hFFFF);
        pop_check("ur_sat2", 48'd0, 1'b1);
        check_val("ur_cnt_hold", 48'(underrun_cnt), 48'hFFFF);

        // Push into an empty FIFO on a data_rd cycle: underrun, pair kept
        @(negedge clk);
        s0_l = 24'hABCDEF; s0_r = 24'h123456; s0_valid = 1'b1; data_rd = 1'b1;
        @(negedge clk);
        s0_valid = 1'b0; data_rd = 1'b0;
        check_val("pu_ur", 48'(underrun), 48'd1);
        check_val("pu_data", {data_l, data_r}, 48'd0);
        check_val("pu_level", 48'(level), 48'd1);
        pop_check("pu_pop", {24'hABCDEF, 24'h123456}, 1'b0);

        // Full FIFO: ready drops, a pop reopens exactly one slot
        s0_valid = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            s0_l = 24'h000010 + 24'(i);
            s0_r = 24'hA00000 + 24'(i);
            @(negedge clk);
        end
        check_val("full_level", 48'(level), 48'(DEPTH));
        s0_l = 24'h000055; s0_r = 24'h000A55; data_rd = 1'b1;
        #1;
        check_val("full_rd_ready", 48'(s0_ready), 48'd0);
        check_val("full_rd_level", 48'(level), 48'(DEPTH));
        @(negedge clk);
        data_rd = 1'b0;
        check_val("full_pop_data", {data_l, data_r}, {24'h000010, 24'hA00000});
        check_val("full_pop_level", 48'(level), 48'(DEPTH - 1));
        check_val("full_pop_ready", 48'(s0_ready), 48'd1);
        @(negedge clk);
        s0_valid = 1'b0;
        check_val("full_refill_level", 48'(level), 48'(DEPTH));
        for (int i = 1; i < DEPTH; i++) begin
            exp_l = 24'h000010 + 24'(i);
            exp_r = 24'hA00000 + 24'(i);
            pop_check("full_drain", {exp_l, exp_r}, 1'b0);
        end
        pop_check("full_drain_last", {24'h000055, 24'h000A55}, 1'b0);
        check_val("full_empty_level", 48'(level), 48'd0);

        // Mute zeroes the popped pair but still consumes it
        push0(24'h123456, 24'h654321);
        push0(24'h000777, 24'h000888);
        mute = 1'b1;
        pop_check("mute_pop", 48'd0, 1'b0);
        check_val("mute_level", 48'(level), 48'd1);
        mute = 1'b0;
        pop_check("unmute_pop", {24'h000777, 24'h000888}, 1'b0);
        mute = 1'b1;
        @(negedge clk);
        check_val("mute_hold", {data_l, data_r}, {24'h000777, 24'h000888});
        mute = 1'b0;

        // Reset with five pairs buffered
        for (int i = 0; i < 5; i++) begin
            push0(24'h000100 + 24'(i), 24'h000200 + 24'(i));
        end
        check_val("pre_rst_level", 48'(level), 48'd5);
        @(negedge clk);
        rst = 1'b1; s0_valid = 1'b1;
        #1;
        check_val("rst2_s0_ready", 48'(s0_ready), 48'd0);
        @(negedge clk);
        rst = 1'b0; s0_valid = 1'b0;
        check_val("rst2_level", 48'(level), 48'd0);
        check_val("rst2_data", {data_l, data_r}, 48'd0);
        check_val("rst2_cnt", 48'(underrun_cnt), 48'd0);
        pop_check("rst2_pop", 48'd0, 1'b1);
        check_val("rst2_cnt1", 48'(underrun_cnt), 48'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
